// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: segment table, scan FSM encoding and pattern decode shared by the
// seven-segment scan decoder.
package seg_scan_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_e;
  // Active-low {g,f,e,d,c,b,a} patterns, entry k displays hex digit k.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  function automatic logic [4:0] seg_to_hex(input logic [6:0] pat);
    logic [4:0] r;
    r = 5'd0;
    for (int k = 0; k < 16; k++)
      if (SEG_LUT[k] == pat) r = {1'b1, k[3:0]};
    return r;
  endfunction
endpackage

// File: rtl/seg_sample_settle.sv
// seg_sample_settle: resynchronises the display bus and strobes a capture once the
// selected digit has been stable for SETTLE_CYCLES samples.
module seg_sample_settle
  import seg_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W = 21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg0,
  input  logic [6:0] seg1,
  input  logic [7:0] anode,
  output logic       cap,
  output logic [2:0] cap_idx,
  output logic [6:0] cap_pat,
  output logic       bad_anode
);
  logic [21:0] sync1_q, sync2_q;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [14:0] prev_q, prev_d, sample;
  logic [7:0] s_an, an_n;
  logic [6:0] sel;
  logic [2:0] idx;
  logic blank, one_low;
  assign s_an = sync2_q[21:14];
  assign an_n = ~s_an;
  always_comb begin
    idx = 3'd0;
    for (int k = 0; k < 8; k++)
      if (an_n[k]) idx = k[2:0];
    sel = idx[2] ? sync2_q[13:7] : sync2_q[6:0];
    sample = {s_an, sel};
    blank = &s_an;
    one_low = |an_n && ~|(an_n & (an_n - 8'd1));
    state_d = state_q;
    cnt_d = cnt_q;
    prev_d = prev_q;
    cap = 1'b0;
    if (blank || !one_low) state_d = IDLE;
    else if (state_q == IDLE || sample != prev_q) begin
      state_d = SETTLE;
      cnt_d = CNT_W'(1);
      prev_d = sample;
    end else if (state_q == SETTLE) begin
      cnt_d = cnt_q + 1'b1;
      cap = cnt_d == CNT_W'(SETTLE_CYCLES);
      state_d = cap ? HOLD : SETTLE;
    end
  end
  assign cap_idx = idx;
  assign cap_pat = sel;
  assign bad_anode = !blank && !one_low;
  // Sync flops reset to a blank display so release never looks like a bad anode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      state_q <= IDLE;
      cnt_q <= '0;
      prev_q <= '0;
    end else begin
      sync1_q <= {anode, seg1, seg0};
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      prev_q <= prev_d;
    end
  end
endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: rebuilds the 32-bit hex value shown on the scanned display and
// flags complete frames, value changes, bad patterns and a stalled scan.
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int CNT_W = 21
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg0,
  input  logic [6:0]  seg1,
  input  logic [7:0]  anode,
  output logic [31:0] value,
  output logic        frame_valid,
  output logic        changed,
  output logic        seg_err,
  output logic        stalled
);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);
  logic cap, bad_anode, hit, full;
  logic [2:0] cap_idx;
  logic [6:0] cap_pat;
  logic [4:0] dec;
  logic [31:0] shadow_q, shadow_d, value_q, value_d;
  logic [7:0] mask_q, mask_d;
  logic fv_q, fv_d, chg_q, chg_d, err_q, err_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  seg_sample_settle #(.SETTLE_CYCLES(SETTLE_CYCLES), .CNT_W(CNT_W)) u_settle (
    .clk(clk), .reset(reset), .seg0(seg0), .seg1(seg1), .anode(anode),
    .cap(cap), .cap_idx(cap_idx), .cap_pat(cap_pat), .bad_anode(bad_anode)
  );
  // A capture landing in the frame-completion cycle belongs to the next frame.
  always_comb begin
    dec = seg_to_hex(cap_pat);
    hit = cap & dec[4];
    full = &mask_q;
    shadow_d = shadow_q;
    if (hit) shadow_d[{cap_idx, 2'b00} +: 4] = dec[3:0];
    mask_d = (full ? 8'h00 : mask_q) | (hit ? 8'h01 << cap_idx : 8'h00);
    value_d = full ? shadow_q : value_q;
    fv_d = full;
    chg_d = full && shadow_q != value_q;
    err_d = err_q | bad_anode | (cap & ~dec[4]);
    tmo_d = cap ? '0 : tmo_q == TMO ? tmo_q : tmo_q + 1'b1;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q <= '0;
      value_q <= '0;
      mask_q <= '0;
      fv_q <= 1'b0;
      chg_q <= 1'b0;
      err_q <= 1'b0;
      tmo_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      value_q <= value_d;
      mask_q <= mask_d;
      fv_q <= fv_d;
      chg_q <= chg_d;
      err_q <= err_d;
      tmo_q <= tmo_d;
    end
  end
  assign value = value_q;
  assign frame_valid = fv_q;
  assign changed = chg_q;
  assign seg_err = err_q;
  assign stalled = tmo_q == TMO;
endmodule
